// File: rtl/reg_wb_pkg.sv
// Shared widths and the FIFO entry type for the register-file writeback unit.
package reg_wb_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of writeback entries; exposes entries oldest-first
// for forwarding when REG_WB_BYPASS_EN is defined.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        push_entry,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
`ifdef REG_WB_BYPASS_EN
    ,
    output wb_entry_t        age_entry [DEPTH],
    output logic [DEPTH-1:0] age_valid
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef REG_WB_BYPASS_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entry[i] = mem[rd_ptr + PTR_W'(i)];
            age_valid[i] = (CNT_W'(i) < count);
        end
    end
`endif

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback: mem-over-ALU arbiter, FIFO drain to the write port,
// destination scoreboard, optional forwarding (REG_WB_BYPASS_EN).
module reg_writeback #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = reg_wb_pkg::ADDR_W,
    parameter int DATA_W = reg_wb_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_addr,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic [ADDR_W-1:0]    write_addr,
    output logic [DATA_W-1:0]    write_data,
    output logic                 write_enable1,
    input  logic [ADDR_W-1:0]    fwd_addr,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data
);

    import reg_wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               mem_take;
    logic               alu_take;
    logic               push;
    logic               pop;
    logic [2**ADDR_W-1:0] busy_next;
    logic               unused_count;

    // Ready looks only at registered occupancy, never at this cycle's pop.
    assign mem_ready = !fifo_full;
    assign alu_ready = !fifo_full && !mem_valid;
    assign mem_take  = mem_valid && mem_ready;
    assign alu_take  = alu_valid && alu_ready;
    assign push      = mem_take || alu_take;
    assign pop       = !fifo_empty;

    assign unused_count = ^fifo_count;

    always_comb begin
        push_entry = '{addr: alu_addr, data: alu_data};
        if (mem_take) begin
            push_entry = '{addr: mem_addr, data: mem_data};
        end
    end

`ifdef REG_WB_BYPASS_EN
    wb_entry_t        age_entry [DEPTH];
    logic [DEPTH-1:0] age_valid;
`endif

    wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
`ifdef REG_WB_BYPASS_EN
        ,
        .age_entry  (age_entry),
        .age_valid  (age_valid)
`endif
    );

    // Set after clear so a re-issue on the retiring address keeps the bit.
    always_comb begin
        busy_next = busy_mask;
        if (write_enable1) begin
            busy_next[write_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_enable1 <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
            busy_mask     <= '0;
        end else begin
            write_enable1 <= pop;
            if (pop) begin
                write_addr <= head.addr;
                write_data <= head.data;
            end
            busy_mask <= busy_next;
        end
    end

`ifdef REG_WB_BYPASS_EN
    // Oldest first, so later (younger) matches overwrite earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (write_enable1 && (write_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (age_valid[i] && (age_entry[i].addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = age_entry[i].data;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised scoreboard bench for reg_writeback against a queue-level reference model.
module tb_reg_writeback;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 alu_valid, alu_ready, mem_valid, mem_ready;
    logic [ADDR_W-1:0]    alu_addr, mem_addr, issue_addr, write_addr, fwd_addr;
    logic [DATA_W-1:0]    alu_data, mem_data, write_data, fwd_data;
    logic                 issue_valid, write_enable1, fwd_hit;
    logic [2**ADDR_W-1:0] busy_mask;

    reg_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .busy_mask(busy_mask),
        .write_addr(write_addr), .write_data(write_data), .write_enable1(write_enable1),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t                 fifo_q[$];
    ent_t                 exp_q[$];
    logic                 m_we;
    logic [ADDR_W-1:0]    m_waddr;
    logic [DATA_W-1:0]    m_wdata;
    logic [2**ADDR_W-1:0] m_busy;
    int                   checks = 0;
    int                   errors = 0;
    bit                   started = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        exp_q.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_busy  = '0;
    endtask

    // One rising edge of the reference: retire head, then accept mem before ALU.
    task automatic model_step();
        int   old_size;
        ent_t e;
        if (!rst_n) return;
        old_size = fifo_q.size();
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (issue_valid) m_busy[issue_addr] = 1'b1;
        if (old_size > 0) begin
            e       = fifo_q.pop_front();
            m_we    = 1'b1;
            m_waddr = e.a;
            m_wdata = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (old_size < DEPTH) begin
            if (mem_valid) begin
                e.a = mem_addr; e.d = mem_data;
                fifo_q.push_back(e); exp_q.push_back(e);
            end else if (alu_valid) begin
                e.a = alu_addr; e.d = alu_data;
                fifo_q.push_back(e); exp_q.push_back(e);
            end
        end
    endtask

    function automatic void fwd_model(input logic [ADDR_W-1:0] a, output logic hit,
                                      output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (m_we && m_waddr == a) begin hit = 1'b1; d = m_wdata; end
        foreach (fifo_q[i]) if (fifo_q[i].a == a) begin hit = 1'b1; d = fifo_q[i].d; end
`ifndef REG_WB_BYPASS_EN
        hit = 1'b0;
        d   = '0;
`endif
    endfunction

    task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                         input logic iv, input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] fa);
        @(posedge clk);
        #1;
        model_step();
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        issue_valid = iv; issue_addr = ia; fwd_addr = fa;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, fwd_addr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        model_step();
        rst_n = 1'b0;
        model_reset();
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, and checks status outputs.
    always @(negedge clk) begin : monitor
        ent_t              e;
        logic              f_hit;
        logic [DATA_W-1:0] f_data;
        if (started) begin
            check("write_enable1", 64'(write_enable1), 64'(m_we));
            if (write_enable1 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: write r%0d=%0h seen, expected no write", write_addr, write_data);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 64'(write_addr), 64'(e.a));
                    check("write_data", 64'(write_data), 64'(e.d));
                end
            end
            if (!rst_n) begin
                check("rst_write_addr", 64'(write_addr), 64'd0);
                check("rst_write_data", 64'(write_data), 64'd0);
            end
            check("busy_mask", 64'(busy_mask), 64'(m_busy));
            check("mem_ready", 64'(mem_ready), 64'(fifo_q.size() < DEPTH));
            check("alu_ready", 64'(alu_ready), 64'((fifo_q.size() < DEPTH) && !mem_valid));
            fwd_model(fwd_addr, f_hit, f_data);
            check("fwd_hit", 64'(fwd_hit), 64'(f_hit));
            check("fwd_data", 64'(fwd_data), 64'(f_data));
        end
    end

    initial begin
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        issue_valid = 0; issue_addr = 0; fwd_addr = 0;
        model_reset();
        started = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        drive(1, 4'd3, 32'hAA, 0, 0, 0, 0, 0, 4'd3);
        idle(3);

        drive(1, 4'd6, 32'h66, 1, 4'd5, 32'h55, 0, 0, 4'd5);
        drive(1, 4'd6, 32'h66, 0, 0, 0, 0, 0, 4'd6);
        idle(3);

        drive(0, 0, 0, 0, 0, 0, 1, 4'd7, 4'd7);
        idle(2);
        drive(1, 4'd7, 32'h77, 0, 0, 0, 0, 0, 4'd7);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1, 4'd7, 4'd7);
        idle(3);
        drive(1, 4'd7, 32'h78, 0, 0, 0, 0, 0, 4'd7);
        idle(3);

        drive(1, 4'd2, 32'h11, 0, 0, 0, 0, 0, 4'd2);
        drive(1, 4'd2, 32'h22, 0, 0, 0, 0, 0, 4'd2);
        idle(1);
        drive(1, 4'd0, 32'h01, 0, 0, 0, 1, 4'd0, 4'd0);
        drive(0, 0, 0, 1, 4'd15, 32'hF00F, 0, 0, 4'd15);
        do_reset();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                      1'($urandom_range(0, 2) == 0), 4'($urandom), $urandom,
                      1'($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));
            end
        end

        idle(5);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
